// File: rtl/collision_scorer_pkg.sv
// Shared constants, state encoding and bus layout for the collision scorer.
package collision_scorer_pkg;

    // Default geometry and timing of the game.
    localparam int N_PIPE_DEF      = 3;
    localparam int BIRD_W_DEF      = 5;
    localparam int PIPE_HALF_DEF   = 2;
    localparam int DEATH_TICKS_DEF = 8;

    // Scene codes used by the controller.
    localparam logic [1:0] SCENE_SPLASH   = 2'd0;
    localparam logic [1:0] SCENE_PLAYING  = 2'd1;
    localparam logic [1:0] SCENE_GAMEOVER = 2'd2;

    // Scorer state machine.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Bus layout: bird = {altitude, is_flapping}; pipe entry = {pos, max, min}.
    localparam int BIRD_BUS_W   = 9;
    localparam int PIPE_ENTRY_W = 24;
    localparam int FIELD_W      = 8;
    localparam int POS_LSB      = 16;
    localparam int MAX_LSB      = 8;
    localparam int MIN_LSB      = 0;

    // Score representation: three packed BCD digits.
    localparam int         BCD_W   = 12;
    localparam logic [11:0] BCD_MAX = 12'h999;

    // Packed BCD orders the same way as binary, so a plain compare picks the max.
    function automatic logic [11:0] bcd_max(input logic [11:0] a, input logic [11:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/collision_scorer_bcd_add3.sv
// Three-digit BCD adder for a small increment, saturating at 999.
module bcd_add3
    import collision_scorer_pkg::*;
(
    input  logic [11:0] a_bcd,
    input  logic [1:0]  inc,
    output logic [11:0] sum_bcd
);

    logic [4:0] d0;
    logic [4:0] d1;
    logic [4:0] d2;
    logic       c0;
    logic       c1;

    // Ripple the increment through the digits; a carry out of the hundreds saturates.
    always_comb begin
        d0      = {1'b0, a_bcd[3:0]} + {3'b000, inc};
        c0      = (d0 > 5'd9);
        if (c0) begin
            d0 = d0 - 5'd10;
        end
        d1      = {1'b0, a_bcd[7:4]} + {4'b0000, c0};
        c1      = (d1 > 5'd9);
        if (c1) begin
            d1 = d1 - 5'd10;
        end
        d2      = {1'b0, a_bcd[11:8]} + {4'b0000, c1};
        sum_bcd = {d2[3:0], d1[3:0], d0[3:0]};
        if ((d2 > 5'd9) || (a_bcd == BCD_MAX)) begin
            sum_bcd = BCD_MAX;
        end
    end

endmodule

// File: rtl/collision_scorer.sv
// Collision detection, BCD scoring, best-score tracking and game-over sequencing.
module collision_scorer
    import collision_scorer_pkg::*;
#(
    parameter int N_PIPE      = N_PIPE_DEF,
    parameter int BIRD_W      = BIRD_W_DEF,
    parameter int PIPE_HALF   = PIPE_HALF_DEF,
    parameter int DEATH_TICKS = DEATH_TICKS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         playing,
    input  logic                         restart,
    input  logic [BIRD_BUS_W-1:0]        bird,
    input  logic [PIPE_ENTRY_W*N_PIPE-1:0] pipes,
    output logic                         hit,
    output logic                         game_over,
    output logic [BCD_W-1:0]             score_bcd,
    output logic [BCD_W-1:0]             best_bcd
);

    localparam int CNT_W = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

    // Horizontal extent of the bird padded by the pipe half-width, at 10-bit signed.
    localparam logic signed [9:0] LEFT_EDGE  = 10'(-PIPE_HALF);
    localparam logic signed [9:0] RIGHT_EDGE = 10'(BIRD_W - 1 + PIPE_HALF);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_PIPE-1:0] scored_q, scored_d;
    logic [BCD_W-1:0]  score_q, score_d;
    logic [BCD_W-1:0]  best_q, best_d;
    logic              hit_q, hit_d;

    logic [7:0]        altitude;
    logic              unused_flap;
    logic [N_PIPE-1:0] overlap;
    logic [N_PIPE-1:0] safe;
    logic [N_PIPE-1:0] cleared;
    logic [N_PIPE-1:0] recycled;
    logic              collision;
    logic [N_PIPE-1:0] new_clear;
    logic [N_PIPE-1:0] scored_after;
    logic [1:0]        inc_cnt;
    logic [BCD_W-1:0]  score_inc;

    assign altitude    = bird[8:1];
    assign unused_flap = bird[0];

    // Per-pipe geometry: overlap window, gap test, and left/right recycling zones.
    generate
        for (genvar gi = 0; gi < N_PIPE; gi++) begin : g_pipe
            logic [7:0]        pos_raw;
            logic [7:0]        max_bnd;
            logic [7:0]        min_bnd;
            logic signed [9:0] pos_ext;

            assign pos_raw = pipes[PIPE_ENTRY_W*gi + POS_LSB +: FIELD_W];
            assign max_bnd = pipes[PIPE_ENTRY_W*gi + MAX_LSB +: FIELD_W];
            assign min_bnd = pipes[PIPE_ENTRY_W*gi + MIN_LSB +: FIELD_W];
            assign pos_ext = $signed({{2{pos_raw[7]}}, pos_raw});

            assign overlap[gi]  = (pos_ext >= LEFT_EDGE) && (pos_ext <= RIGHT_EDGE);
            assign safe[gi]     = (min_bnd < altitude) && (altitude < max_bnd);
            assign cleared[gi]  = (pos_ext < LEFT_EDGE);
            assign recycled[gi] = !pos_ext[9];
        end
    endgenerate

    // Altitude 0 or anything with the top bit set counts as hitting the floor.
    assign collision = (|(overlap & ~safe)) || (altitude == 8'd0) || altitude[7];

    // Count pipes newly passed this tick and update the per-pipe scored flags.
    always_comb begin
        new_clear    = cleared & ~scored_q;
        scored_after = (scored_q | cleared) & ~recycled;
        inc_cnt      = 2'd0;
        for (int i = 0; i < N_PIPE; i++) begin
            inc_cnt = inc_cnt + {1'b0, new_clear[i]};
        end
    end

    bcd_add3 u_bcd_add3 (
        .a_bcd   (score_q),
        .inc     (inc_cnt),
        .sum_bcd (score_inc)
    );

    // Next-state logic: game phase, death countdown, score and best score.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        scored_d = scored_q;
        score_d  = score_q;
        best_d   = best_q;
        hit_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (playing) begin
                    state_d  = ST_RUN;
                    score_d  = '0;
                    scored_d = '0;
                end
            end
            ST_RUN: begin
                if (!playing) begin
                    state_d = ST_OVER;
                    best_d  = bcd_max(best_q, score_q);
                end else begin
                    score_d  = score_inc;
                    scored_d = scored_after;
                    if (collision) begin
                        state_d = ST_DYING;
                        hit_d   = 1'b1;
                        cnt_d   = CNT_W'(DEATH_TICKS - 1);
                    end
                end
            end
            ST_DYING: begin
                if (cnt_q == '0) begin
                    state_d = ST_OVER;
                    best_d  = bcd_max(best_q, score_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_OVER: begin
                if (restart) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            scored_q <= '0;
            score_q  <= '0;
            best_q   <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            scored_q <= scored_d;
            score_q  <= score_d;
            best_q   <= best_d;
            hit_q    <= hit_d;
        end
    end

    assign hit       = hit_q;
    assign game_over = (state_q == ST_OVER);
    assign score_bcd = score_q;
    assign best_bcd  = best_q;

endmodule
